// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Optional build macro: ALU_SEQ_STICKY_CARRY_EN (see alu_sequencer.sv).
package alu_seq_pkg;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOR = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/alu_sequencer_if.sv
// Command / response handshake bundle between a requester and the sequencer.
interface alu_sequencer_if;
  import alu_seq_pkg::*;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_operand;
  logic [CNT_W-1:0]  cmd_count;
  logic              cmd_load;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_carry;

  modport master (output cmd_valid, cmd_op, cmd_operand, cmd_count, cmd_load, rsp_ready,
                  input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry);
  modport slave  (input  cmd_valid, cmd_op, cmd_operand, cmd_count, cmd_load, rsp_ready,
                  output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry);
endinterface

// File: rtl/alu_seq_alu.sv
// Combinational 8-bit ALU; carry is add carry-out, sub borrow, or the bit shifted out.
module alu_seq_alu
  import alu_seq_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        ctrl,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry
);
  logic [DATA_W:0] wide;

  always_comb begin
    wide = '0;
    case (op_t'(ctrl))
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      OP_NOR:  wide = {1'b0, ~(a | b)};
      OP_SHL:  wide = {a, 1'b0};
      OP_SHR:  wide = {a[0], 1'b0, a[DATA_W-1:1]};
      default: wide = '0;
    endcase
  end

  assign result = wide[DATA_W-1:0];
  assign carry  = wide[DATA_W];
  assign zero   = (result == '0);
endmodule

// File: rtl/alu_seq_top.sv
// Sequencer paired with the 8-bit ALU it drives.
module alu_seq_top
  import alu_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  alu_sequencer_if.slave bus,
  output logic           busy
);
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]        alu_control;
  logic              alu_zero, alu_carry;

  alu_sequencer u_seq (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .busy(busy)
  );

  alu_seq_alu u_alu (
    .a(alu_a), .b(alu_b), .ctrl(alu_control),
    .result(alu_result), .zero(alu_zero), .carry(alu_carry)
  );
endmodule

// File: rtl/alu_sequencer.sv
// Repeats one ALU op N times on an accumulator, then holds the result until taken.
// Optional build macro: ALU_SEQ_STICKY_CARRY_EN (carry accumulates until next load/reset).
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_sequencer_if.slave    bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic              busy
);
  state_t            state, nxt;
  logic [DATA_W-1:0] acc, opnd_q;
  logic [2:0]        op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              zero_q, carry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (bus.cmd_valid) nxt = bus.cmd_load ? ST_RESP : ST_EXEC;
      ST_EXEC: if (cnt_q == CNT_ONE) nxt = ST_RESP;
      ST_RESP: if (bus.rsp_ready) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state == ST_IDLE);
    bus.rsp_valid = (state == ST_RESP);
    busy          = (state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.cmd_valid) begin
          op_q   <= bus.cmd_op;
          opnd_q <= bus.cmd_operand;
          cnt_q  <= (bus.cmd_count == '0) ? CNT_ONE : bus.cmd_count;
          if (bus.cmd_load) begin
            acc     <= bus.cmd_operand;
            zero_q  <= (bus.cmd_operand == '0);
            carry_q <= 1'b0;
          end
        end
        ST_EXEC: begin
          acc    <= alu_result;
          zero_q <= alu_zero;
`ifdef ALU_SEQ_STICKY_CARRY_EN
          carry_q <= carry_q | alu_carry;
`else
          carry_q <= alu_carry;
`endif
          cnt_q <= cnt_q - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  // ALU operands come straight from state registers, so no cmd/rsp path reaches the ALU.
  assign alu_a       = acc;
  assign alu_b       = opnd_q;
  assign alu_control = op_q;

  assign bus.rsp_result = acc;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_carry  = carry_q;
endmodule
